// File: rtl/cbus_mem_responder.sv
// CBus slave memory model: accepts one request at a time, waits a programmable
// latency, then streams back-to-back read or write beats against a word array.

package cbus_pkg;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_mem_responder
  import cbus_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_TURN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [3:0]  bcnt_q, bcnt_d;
  idx_t        idx_q, idx_d;
  logic        wr_q, wr_d;
  logic        fixed_q, fixed_d;
  logic        ready_q, ready_d;
  logic        last_q, last_d;
  logic [63:0] data_q, data_d;
  logic [63:0] mem_q [DEPTH];

  idx_t req_idx;
  logic unused_bits;
  assign req_idx     = creq.addr[3 +: DEPTH_LOG2];
  assign unused_bits = ^{creq.size, creq.addr[63:3+DEPTH_LOG2], creq.addr[2:0]};

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    fixed_d = fixed_q;
    ready_d = 1'b0;
    last_d  = 1'b0;
    data_d  = data_q;
    case (state_q)
      S_IDLE: if (creq.valid) begin
        idx_d   = req_idx;
        wr_d    = creq.is_write;
        fixed_d = (creq.burst == BURST_FIXED);
        bcnt_d  = creq.len;
        wcnt_d  = WAIT_INIT;
        state_d = (WAIT_INIT == 4'd0) ? S_BEAT : S_WAIT;
      end
      S_WAIT: begin
        if (!creq.valid) begin
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_d = S_BEAT;
        end
      end
      S_BEAT: begin
        // bcnt_q counts the beats still to follow the current one
        if (!creq.valid) begin
          state_d = S_IDLE;
        end else if (bcnt_q == 4'd0) begin
          state_d = S_TURN;
        end else begin
          bcnt_d = bcnt_q - 4'd1;
          if (!fixed_q) idx_d = idx_q + idx_t'(1);
        end
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decided one cycle ahead so the beat cycle sees them registered.
    if (state_d == S_BEAT) begin
      ready_d = 1'b1;
      last_d  = (bcnt_d == 4'd0);
      if (!wr_d) data_d = mem_q[idx_d];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      fixed_q <= 1'b0;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      fixed_q <= fixed_d;
      ready_q <= ready_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  // NOTE: the word array has no reset; contents survive reset, and an async
  // reset clears ready_q at once so an interrupted beat never commits.
  always_ff @(posedge clk) begin
    if (ready_q && wr_q) begin
      for (int i = 0; i < 8; i++) begin
        if (creq.strobe[i]) mem_q[idx_q][8*i +: 8] <= creq.data[8*i +: 8];
      end
    end
  end

  assign cresp.ready = ready_q;
  assign cresp.last  = last_q;
  assign cresp.data  = data_q;

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Randomised bench for cbus_mem_responder: a transaction-level model predicts
// every cycle's response, and a single negedge process compares against it.

module tb_cbus_mem_responder;
  import cbus_pkg::*;

  localparam int DL    = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << DL;

  logic       clk;
  logic       rst;
  cbus_req_t  req;
  cbus_resp_t resp;

  cbus_mem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (rst),
    .creq  (req),
    .cresp (resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  logic [63:0] model_mem [DEPTH];
  logic [63:0] wdata_tab [16];
  logic [7:0]  wstrb_tab [16];

  logic        chk_en;
  logic        exp_ready;
  logic        exp_last;
  logic        exp_dknown;
  logic [63:0] exp_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: outputs are meaningful every cycle once checking is on.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 64'(resp.ready), 64'(exp_ready));
      check("last", 64'(resp.last), 64'(exp_last));
      if (exp_dknown) check("data", resp.data, exp_data);
    end
  end

  function automatic int widx(input logic [63:0] addr);
    return int'((addr >> 3) % DEPTH);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      req        = '0;
      req.data   = {$urandom, $urandom};
      req.strobe = 8'($urandom);
      exp_ready  = 1'b0;
      exp_last   = 1'b0;
    end
  endtask

  // One transaction from acceptance (cycle 0) to TURN, or until an abort/reset cycle.
  task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input int drop_at, input int rst_at,
                         input logic b2b);
    int nb;
    int base;
    int turn_c;
    int k;
    int ix;
    nb     = int'(len) + 1;
    base   = widx(addr);
    turn_c = LAT + nb;
    for (int c = 0; c <= turn_c; c++) begin
      k = c - LAT;
      next_cycle();
      if (c == 0) begin
        req.is_write = wr;
        req.addr     = addr;
        req.len      = len;
        req.burst    = burst;
        req.size     = 3'd3;
      end else begin
        req.is_write = 1'($urandom);
        req.addr     = {$urandom, $urandom};
        req.len      = 4'($urandom);
        req.burst    = 2'($urandom);
        req.size     = 3'($urandom);
      end
      if (c == turn_c) req.valid = b2b;
      else req.valid = (drop_at < 0 || c < drop_at) && (c != rst_at);
      if (wr && k >= 0 && k < nb) begin
        req.data   = wdata_tab[k];
        req.strobe = wstrb_tab[k];
      end else begin
        req.data   = {$urandom, $urandom};
        req.strobe = 8'($urandom);
      end
      if (c == rst_at) rst = 1'b0;

      exp_ready = 1'b0;
      exp_last  = 1'b0;
      if (rst_at >= 0 && c >= rst_at) begin
        exp_dknown = 1'b1;
        exp_data   = '0;
      end else if (k >= 0 && k < nb) begin
        ix        = (burst == BURST_FIXED) ? base : (base + k) % DEPTH;
        exp_ready = 1'b1;
        exp_last  = (k == nb - 1);
        if (wr) begin
          for (int b = 0; b < 8; b++)
            if (wstrb_tab[k][b]) model_mem[ix][8*b +: 8] = wdata_tab[k][8*b +: 8];
          exp_dknown = 1'b0;
        end else begin
          exp_data   = model_mem[ix];
          exp_dknown = 1'b1;
        end
      end
      if (c == drop_at || c == rst_at) break;
    end
  endtask

  task automatic fill_tabs();
    for (int i = 0; i < 16; i++) begin
      wdata_tab[i] = {$urandom, $urandom};
      wstrb_tab[i] = 8'($urandom);
    end
  endtask

  task automatic peek_all(input string name);
    for (int i = 0; i < DEPTH; i++) check(name, dut.mem_q[i], model_mem[i]);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    req        = '0;
    rst        = 1'b0;
    chk_en     = 1'b0;
    exp_ready  = 1'b0;
    exp_last   = 1'b0;
    exp_dknown = 1'b1;
    exp_data   = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_ready", 64'(resp.ready), 64'd0);
    check("reset_data", resp.data, 64'd0);
    next_cycle();
    rst = 1'b1;
    idle(2);

    // mem[i] = i over the whole array, then a 16-beat INCR read
    for (int i = 0; i < 16; i++) begin
      wdata_tab[i] = 64'(i);
      wstrb_tab[i] = 8'hFF;
    end
    run_txn(1'b1, 64'h0, 4'd15, BURST_INCR, -1, -1, 1'b0);
    check("pin_incr_model", model_mem[9], 64'd9);
    idle(1);
    run_txn(1'b0, 64'h0, 4'd15, BURST_INCR, -1, -1, 1'b0);

    // single read; word 0x10 aliases to word 0 with a 16-word array
    wdata_tab[0] = 64'hDEADBEEF_01234567;
    wstrb_tab[0] = 8'hFF;
    run_txn(1'b1, 64'h80, 4'd0, BURST_INCR, -1, -1, 1'b0);
    run_txn(1'b0, 64'h80, 4'd0, BURST_INCR, -1, -1, 1'b0);
    check("pin_single_read", exp_data, 64'hDEADBEEF_01234567);

    // strobed single write
    wdata_tab[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_txn(1'b1, 64'h10, 4'd0, BURST_INCR, -1, -1, 1'b0);
    wdata_tab[0] = 64'h1122334455667788;
    wstrb_tab[0] = 8'h0F;
    run_txn(1'b1, 64'h10, 4'd0, BURST_INCR, -1, -1, 1'b0);
    idle(1);
    check("strobe_mem2", dut.mem_q[2], 64'hFFFFFFFF55667788);
    check("pin_strobe_model", model_mem[2], 64'hFFFFFFFF55667788);

    // wrap: INCR len=3 from word 14 reads 14, 15, 0, 1
    run_txn(1'b0, 64'(14 * 8), 4'd3, BURST_INCR, -1, -1, 1'b0);

    // FIXED write of 1..4 to word 5 leaves 4
    for (int i = 0; i < 4; i++) begin
      wdata_tab[i] = 64'(i + 1);
      wstrb_tab[i] = 8'hFF;
    end
    run_txn(1'b1, 64'(5 * 8), 4'd3, BURST_FIXED, -1, -1, 1'b0);
    idle(1);
    check("fixed_mem5", dut.mem_q[5], 64'd4);

    // valid dropped during WAIT, then mid-burst during a write
    run_txn(1'b0, 64'h40, 4'd3, BURST_INCR, 1, -1, 1'b0);
    idle(1);
    fill_tabs();
    run_txn(1'b1, 64'(8 * 8), 4'd5, BURST_INCR, LAT + 2, -1, 1'b0);
    idle(1);
    peek_all("mem_after_drop");

    // reset after beat 2 of an 8-beat write; memory must keep beats 1-2 only
    fill_tabs();
    for (int i = 0; i < 8; i++) wstrb_tab[i] = 8'hFF;
    run_txn(1'b1, 64'(3 * 8), 4'd7, BURST_INCR, -1, LAT + 2, 1'b0);
    idle(2);
    next_cycle();
    rst = 1'b1;
    idle(1);
    peek_all("mem_after_reset");
    run_txn(1'b0, 64'(3 * 8), 4'd7, BURST_INCR, -1, -1, 1'b0);

    // back-to-back: valid re-presented in TURN is ignored, accepted next cycle
    run_txn(1'b0, 64'h20, 4'd1, BURST_INCR, -1, -1, 1'b1);
    run_txn(1'b0, 64'h30, 4'd2, BURST_FIXED, -1, -1, 1'b0);

    // randomised traffic
    for (int t = 0; t < 80; t++) begin
      logic       wr;
      logic [3:0] len;
      logic [1:0] burst;
      int         drop;
      logic       b2b;
      wr    = 1'($urandom);
      len   = 4'($urandom);
      burst = ($urandom_range(0, 1) == 0) ? BURST_FIXED : BURST_INCR;
      drop  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, LAT + int'(len))) : -1;
      b2b   = (drop < 0) && ($urandom_range(0, 2) == 0);
      fill_tabs();
      run_txn(wr, {$urandom, $urandom}, len, burst, drop, -1, b2b);
      if (!b2b) idle(int'($urandom_range(0, 2)));
    end
    idle(2);
    peek_all("mem_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cbus_mem_responder.md
Name: cbus_mem_responder

Overview:
- Cycle-accurate CBus slave memory model: the far end of the core's uncached/cached memory bus, the block that consumes `oreq` and drives `oresp`.
- Sits below the CBus arbiter in simulation tops and replaces the external memory for unit and integration benches.
- Serves single and burst reads/writes against an internal word array, with programmable first-beat latency.

Parameters:
- `DEPTH_LOG2`, 12: word array holds 2^DEPTH_LOG2 64-bit words; word index = `addr[3 +: DEPTH_LOG2]` (upper bits ignored, aliasing).
- `LATENCY`, 2: cycles from request acceptance to the first beat; legal range 1..15.

Ports:
- `clk` input 1: clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low reset (0 = reset asserted).
- `creq` input `cbus_req_t`: valid(1), is_write(1), size(3), addr(64), strobe(8), data(64), len(4), burst(2).
- `cresp` output `cbus_resp_t`: ready(1), last(1), data(64).

Behaviour:
- Reset (reset=0, asynchronous): `cresp.ready`=0, `cresp.last`=0, `cresp.data`=0, state=IDLE, counters cleared. The memory array is NOT cleared. A reset mid-burst aborts the transaction; no partial-beat write is committed after reset asserts.
- Outputs are registered; no combinational path from `creq` to `cresp`.
- Beat count = len+1 (MLEN1=0 → 1 beat, MLEN16=15 → 16 beats).
- Burst INCR: word index advances by 1 per beat and wraps modulo 2^DEPTH_LOG2.
- Burst FIXED: same index every beat.
- `size` does not alter addressing; every beat is a full 64-bit word.
- States:
  - IDLE: on `creq.valid`=1, latch addr index, is_write, len, burst; load wait counter with LATENCY-1; go to WAIT.
  - WAIT: decrement each cycle; when the counter is 0, go to BEAT.
  - BEAT: each cycle in BEAT asserts `cresp.ready`=1 for exactly one cycle per beat, so beats are back-to-back with no gaps. `cresp.last`=1 coincides with ready on the final beat; after the final beat, go to TURN.
  - TURN: exactly one idle cycle with ready=0; `creq` is ignored; go to IDLE. This guarantees the initiator has dropped valid before re-acceptance.
- Read beat:
  - `cresp.data` = mem[current index], presented in the same cycle as ready=1.
  - data holds its last value when ready=0.
- Write beat:
  - On the cycle ready=1, write byte lane i of `creq.data` into mem[current index] where `creq.strobe[i]`=1.
  - Write data and strobe are sampled on that beat's cycle, not at acceptance.
- Request withdrawn (`creq.valid`=0 while in WAIT or BEAT):
  - Protocol violation; the transaction is abandoned and the next state is IDLE.
  - A beat already asserted that cycle completes; no further writes occur.
  - This case has no assertion; the RTL must handle it silently.
- Accepted request fields are latched. Later changes to addr, len or burst during the transaction are ignored; data and strobe are not latched.
- Latency: the first beat's ready asserts exactly LATENCY cycles after the IDLE cycle in which valid was sampled. Minimum request-to-request period = LATENCY + beats + 1 cycles.
- Simulation-only backdoor: tasks to load and peek words are allowed; they are not ports.

Test Plan:
- Single read, LATENCY=2:
  - Stimulus: preload mem[0x10]=0xDEADBEEF_01234567; request addr=0x80, len=0, read, valid held until last.
  - Response: ready=last=1 exactly 2 cycles after acceptance; data=0xDEADBEEF_01234567; ready=0 the next cycle (TURN).
- Strobed single write:
  - Stimulus: mem[0x2]=0xFFFF_FFFF_FFFF_FFFF; write addr=0x10, data=0x1122334455667788, strobe=0x0F.
  - Response: mem[0x2]=0xFFFFFFFF55667788.
- INCR read burst:
  - Stimulus: len=MLEN16 (15) at addr=0x0; mem[i]=i.
  - Response: 16 consecutive ready cycles with data 0..15; last only on the 16th beat.
- Wrap and FIXED bursts, DEPTH_LOG2=4:
  - INCR len=3 at word 14 reads words 14, 15, 0, 1.
  - FIXED write len=3 to word 5 with data 1, 2, 3, 4 leaves mem[5]=4.
- Abort and reset:
  - Drop valid during WAIT: no ready asserts, returns to IDLE.
  - Assert reset mid-write-burst after beat 2 of 8: ready/last=0 immediately; only beats 1–2 are written; a new read after reset release succeeds.
- Back-to-back requests:
  - Stimulus: re-present valid the cycle after last.
  - Response: ignored during TURN; accepted the following cycle; first beat LATENCY cycles later.
